fb_write_arbiter: RTL and testbench

- Shares the single framebuffer memory-master port between NUM_REQ raster shading lanes.
- Each lane presents one shaded pixel (x, y, 10-bit RGB). The block arbitrates round-robin, computes the framebuffer byte address, packs the colour word and runs the write/acknowledge handshake.
- Sits between the raster shading stage and the external memory interface. It replaces the ad-hoc per-rasterizer write states.

---
 rtl/fb_pkg.sv | 40 ++++
 rtl/fb_write_arbiter_rr_arbiter.sv | 39 +++
 rtl/fb_write_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared types, defaults and helpers for the framebuffer write path.
//   FB_*_DEFAULT : default framebuffer geometry and base address
//   COLOR_W      : bits per colour channel
//   COORD_W      : bits per pixel coordinate
//   pixel_t      : one shaded pixel {x, y, r, g, b}
//   fb_state_e   : write-arbiter state encoding
//   pack_color() : builds the 32-bit framebuffer colour word
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam logic [31:0] FB_BASE_DEFAULT   = 32'h3200_0000;
  localparam int          FB_WIDTH_DEFAULT  = 800;
  localparam int          FB_HEIGHT_DEFAULT = 600;

  localparam int COLOR_W = 10;
  localparam int COORD_W = 10;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pixel_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } fb_state_e;

  // Framebuffer word layout: two spare MSBs, then R, G, B.
  function automatic logic [31:0] pack_color(input logic [COLOR_W-1:0] r,
                                             input logic [COLOR_W-1:0] g,
                                             input logic [COLOR_W-1:0] b);
    return {2'b00, r, g, b};
  endfunction

endpackage

// File: rtl/fb_write_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts at the lane after
// last_grant and wraps, so last_grant = N-1 makes lane 0 highest priority.
//   N          : number of requesters
//   req        : in,  N      request vector
//   last_grant : in,  log2 N index of the previously granted requester
//   grant      : out, N      one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]                        req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] last_grant,
  output logic [N-1:0]                        grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] idx_s;
  logic          found_s;

  // Rotating first-one search starting just after the last winner.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 1; k <= N; k++) begin
      idx_s = IW'((int'(last_grant) + k) % N);
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
// Shares the framebuffer memory-master port between NUM_REQ shading lanes.
// Arbitrates round-robin, computes the pixel byte address, packs the colour
// word and runs the write/acknowledge handshake with an acknowledge timeout.
//
// Optional build macro: FB_CLIP_EN
//   When defined, pixels outside FB_WIDTH x FB_HEIGHT are accepted but not
//   written and are counted on clip_count (16-bit, saturating).
//
// Ports:
//   pll_clock, sys_reset_n                  : clock, async active-low reset
//   req_valid / req_ready [NUM_REQ]          : per-lane handshake
//   req_x, req_y [NUM_REQ*10]                : pixel coordinates
//   req_color [NUM_REQ*30]                   : {R,G,B} 10 bits each
//   gpu_main_external_interface_*            : memory master (write only)
//   grant_id                                 : lane of current/last write
//   busy                                     : high while a write is pending
//   timeout_err                              : sticky acknowledge timeout
//   clip_count (FB_CLIP_EN only)             : dropped out-of-bounds pixels
// -----------------------------------------------------------------------------
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int          NUM_REQ     = 2,
  parameter logic [31:0] FB_BASE     = FB_BASE_DEFAULT,
  parameter int          FB_WIDTH    = FB_WIDTH_DEFAULT,
  parameter int          FB_HEIGHT   = FB_HEIGHT_DEFAULT,
  parameter int          ACK_TIMEOUT = 255,
  localparam int         IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       pll_clock,
  input  logic                       sys_reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  input  logic [NUM_REQ*3*COLOR_W-1:0] req_color,
  output logic [31:0]                gpu_main_external_interface_address,
  output logic                       gpu_main_external_interface_write,
  output logic                       gpu_main_external_interface_read,
  output logic [3:0]                 gpu_main_external_interface_byte_enable,
  output logic [31:0]                gpu_main_external_interface_write_data,
  input  logic                       gpu_main_external_interface_acknowledge,
  output logic [IDW-1:0]             grant_id,
  output logic                       busy,
`ifdef FB_CLIP_EN
  output logic [15:0]                clip_count,
`endif
  output logic                       timeout_err
);

  localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam int               PIX_W    = 3 * COLOR_W;

  // Elaboration-time guard against unsupported configurations.
  if (NUM_REQ < 2 || NUM_REQ > 8 || ACK_TIMEOUT < 1 || FB_WIDTH < 1 || FB_HEIGHT < 1) begin : g_param_check
    $error("fb_write_arbiter: unsupported parameter value");
  end

  fb_state_e         state_q, state_d;
  logic [31:0]       addr_q,  addr_d;
  logic [31:0]       data_q,  data_d;
  logic [3:0]        be_q,    be_d;
  logic              wr_q,    wr_d;
  logic [IDW-1:0]    gid_q,   gid_d;
  logic [IDW-1:0]    last_q,  last_d;
  logic              terr_q,  terr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic [NUM_REQ-1:0] grant_s;
  logic [IDW-1:0]     grant_idx_s;
  pixel_t             sel_pix_s;
  logic [31:0]        pix_addr_s;
  logic               clip_hit_s;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_q),
    .grant      (grant_s)
  );

  // Lanes are only offered acceptance while no write is outstanding.
  assign req_ready = (state_q == IDLE) ? grant_s : '0;

  // Mux the winning lane's pixel and index out of the packed request buses.
  always_comb begin
    grant_idx_s = '0;
    sel_pix_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_idx_s = grant_s[i] ? IDW'(i) : grant_idx_s;
      sel_pix_s   = grant_s[i] ? pixel_t'{
                      x: req_x[i*COORD_W +: COORD_W],
                      y: req_y[i*COORD_W +: COORD_W],
                      r: req_color[i*PIX_W + 2*COLOR_W +: COLOR_W],
                      g: req_color[i*PIX_W +   COLOR_W +: COLOR_W],
                      b: req_color[i*PIX_W             +: COLOR_W]}
                    : sel_pix_s;
    end
  end

  // Byte address of the pixel; 32-bit arithmetic wraps naturally.
  assign pix_addr_s = FB_BASE +
                      (((32'(sel_pix_s.y) * 32'(FB_WIDTH)) + 32'(sel_pix_s.x)) << 2);

`ifdef FB_CLIP_EN
  logic [15:0] clip_q;

  assign clip_hit_s = (32'(sel_pix_s.x) >= 32'(FB_WIDTH)) ||
                      (32'(sel_pix_s.y) >= 32'(FB_HEIGHT));

  // Saturating count of accepted pixels that fell outside the framebuffer.
  always_ff @(posedge pll_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      clip_q <= 16'd0;
    end else if ((state_q == IDLE) && (|grant_s) && clip_hit_s && (clip_q != 16'hFFFF)) begin
      clip_q <= clip_q + 16'd1;
    end else begin
      clip_q <= clip_q;
    end
  end

  assign clip_count = clip_q;
`else
  assign clip_hit_s = 1'b0;
`endif

  // Next-state and next-output logic for the accept/write handshake.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    wr_d    = wr_q;
    gid_d   = gid_q;
    last_d  = last_q;
    terr_d  = terr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|grant_s) begin
          // The pointer advances even for a clipped pixel.
          last_d = grant_idx_s;
          if (clip_hit_s) begin
            state_d = IDLE;
          end else begin
            addr_d  = pix_addr_s;
            data_d  = pack_color(sel_pix_s.r, sel_pix_s.g, sel_pix_s.b);
            be_d    = 4'hF;
            wr_d    = 1'b1;
            gid_d   = grant_idx_s;
            cnt_d   = '0;
            state_d = WRITE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Acknowledge has priority over a coincident timeout.
        if (gpu_main_external_interface_acknowledge) begin
          wr_d    = 1'b0;
          be_d    = 4'h0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          wr_d    = 1'b0;
          be_d    = 4'h0;
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        wr_d    = 1'b0;
        be_d    = 4'h0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves lane 0 as highest priority.
  always_ff @(posedge pll_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q <= IDLE;
      addr_q  <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      be_q    <= 4'h0;
      wr_q    <= 1'b0;
      gid_q   <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gpu_main_external_interface_address     = addr_q;
  assign gpu_main_external_interface_write       = wr_q;
  assign gpu_main_external_interface_read        = 1'b0;
  assign gpu_main_external_interface_byte_enable = be_q;
  assign gpu_main_external_interface_write_data  = data_q;
  assign grant_id                                = gid_q;
  assign busy                                    = (state_q == WRITE);
  assign timeout_err                             = terr_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_write_arbiter
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a transaction-level reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_fb_write_arbiter;

  localparam int N     = 2;
  localparam int W     = 800;
  localparam int H     = 600;
  localparam int ACK_T = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*10-1:0] req_x;
  logic [N*10-1:0] req_y;
  logic [N*30-1:0] req_color;
  logic [31:0]     addr;
  logic            wr;
  logic            rd;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic            ack;
  logic [$clog2(N)-1:0] gid;
  logic            busy;
  logic            terr;
`ifdef FB_CLIP_EN
  logic [15:0]     clip_count;
`endif

  fb_write_arbiter #(.NUM_REQ(N)) dut (
    .pll_clock                               (clk),
    .sys_reset_n                             (rst_n),
    .req_valid                               (req_valid),
    .req_ready                               (req_ready),
    .req_x                                   (req_x),
    .req_y                                   (req_y),
    .req_color                               (req_color),
    .gpu_main_external_interface_address     (addr),
    .gpu_main_external_interface_write       (wr),
    .gpu_main_external_interface_read        (rd),
    .gpu_main_external_interface_byte_enable (be),
    .gpu_main_external_interface_write_data  (wdata),
    .gpu_main_external_interface_acknowledge (ack),
    .grant_id                                (gid),
    .busy                                    (busy),
`ifdef FB_CLIP_EN
    .clip_count                              (clip_count),
`endif
    .timeout_err                             (terr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Lane-side stimulus state.
  bit         lv[N];
  logic [9:0] lx[N], ly[N], lr[N], lg[N], lb[N];

  // Reference model: transaction-level view of the arbiter.
  bit          m_busy;
  int          m_wait;
  int          m_last;
  int          m_gid;
  logic [31:0] m_addr, m_data;
  bit          m_terr;
  int          m_clip;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_last = N - 1; m_gid = 0;
    m_addr = 32'h0; m_data = 32'h0; m_terr = 0; m_clip = 0;
  endtask

  task automatic new_pixel(input int i);
    lv[i] = 1;
    lx[i] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, W - 1));
    ly[i] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, H - 1));
    lr[i] = 10'($urandom); lg[i] = 10'($urandom); lb[i] = 10'($urandom);
  endtask

  task automatic set_pixel(input int i, input int x, input int y, input int r, input int g, input int b);
    lv[i] = 1; lx[i] = 10'(x); ly[i] = 10'(y); lr[i] = 10'(r); lg[i] = 10'(g); lb[i] = 10'(b);
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model.
  task automatic step(input bit ack_in, output int acc);
    logic [N-1:0] er;
    logic [31:0]  a;
    int           pick;
    bit           oob;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = lv[i];
      req_x[10*i +: 10]     = lx[i];
      req_y[10*i +: 10]     = ly[i];
      req_color[30*i +: 30] = {lr[i], lg[i], lb[i]};
    end
    ack = ack_in;
    #4;
    pick = -1;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        if (pick < 0 && lv[(m_last + k) % N]) pick = (m_last + k) % N;
      end
    end
    er = '0;
    if (pick >= 0) er[pick] = 1'b1;
    check_val("ready", 32'(req_ready), 32'(er));
    check_val("write", 32'(wr), 32'(m_busy));
    check_val("busy", 32'(busy), 32'(m_busy));
    check_val("byte_enable", 32'(be), m_busy ? 32'hF : 32'h0);
    check_val("address", addr, m_addr);
    check_val("write_data", wdata, m_data);
    check_val("grant_id", 32'(gid), 32'(m_gid));
    check_val("timeout_err", 32'(terr), 32'(m_terr));
    check_val("read", 32'(rd), 32'h0);
`ifdef FB_CLIP_EN
    check_val("clip_count", 32'(clip_count), 32'(m_clip));
`endif
    if (pick >= 0) begin
      oob = 0;
`ifdef FB_CLIP_EN
      oob = (int'(lx[pick]) >= W) || (int'(ly[pick]) >= H);
`endif
      m_last = pick;
      if (oob) begin
        if (m_clip < 65535) m_clip++;
      end else begin
        a      = 32'(int'(ly[pick]) * W + int'(lx[pick]));
        m_addr = 32'h3200_0000 + a * 32'd4;
        m_data = {2'b00, lr[pick], lg[pick], lb[pick]};
        m_gid  = pick;
        m_busy = 1;
        m_wait = 0;
      end
    end else if (m_busy) begin
      m_wait++;
      if (ack_in) m_busy = 0;
      else if (m_wait == ACK_T) begin m_busy = 0; m_terr = 1; end
    end
    acc = pick;
    @(posedge clk);
    #1;
    if (pick >= 0) lv[pick] = 0;
  endtask

  initial begin
    int acc;
    int cnt;
    logic [31:0] held_addr, held_data;

    for (int i = 0; i < N; i++) begin lv[i] = 0; lx[i] = '0; ly[i] = '0; lr[i] = '0; lg[i] = '0; lb[i] = '0; end
    req_valid = '0; req_x = '0; req_y = '0; req_color = '0; ack = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_address", addr, 32'h0);
    check_val("rst_write", 32'(wr), 32'h0);
    check_val("rst_byte_enable", 32'(be), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_timeout_err", 32'(terr), 32'h0);
    rst_n = 1'b1;

    // Single pixel on lane 0 with a one-cycle acknowledge.
    set_pixel(0, 3, 2, 10'h3FF, 0, 0);
    step(0, acc);
    check_val("single_accept", 32'(acc), 32'h0);
    check_val("single_address", addr, 32'h3200_190C);
    check_val("single_data", wdata, 32'h3FF0_0000);
    check_val("single_be", 32'(be), 32'hF);
    step(1, acc);
    step(0, acc);

    // Acknowledge delayed 5 cycles with both lanes waiting.
    new_pixel(0); new_pixel(1);
    step(0, acc);
    held_addr = addr; held_data = wdata;
    new_pixel(acc);
    for (int c = 0; c < 5; c++) step(0, acc);
    check_val("delay_addr_held", addr, held_addr);
    check_val("delay_data_held", wdata, held_data);
    check_val("delay_still_writing", 32'(wr), 32'h1);
    step(1, acc);
    step(0, acc);
    check_val("delay_next_grant", 32'(acc >= 0), 32'h1);
    step(1, acc);

    // Acknowledge never arrives: timeout after exactly ACK_T write cycles.
    for (int i = 0; i < N; i++) lv[i] = 0;
    step(0, acc);
    set_pixel(0, 10, 10, 1, 2, 3);
    step(0, acc);
    cnt = 0;
    while (wr && cnt < 300) begin cnt++; step(0, acc); end
    check_val("timeout_cycles", 32'(cnt), 32'(ACK_T));
    check_val("timeout_flag", 32'(terr), 32'h1);
    set_pixel(1, 5, 6, 7, 8, 9);
    step(0, acc);
    check_val("after_timeout_accept", 32'(acc), 32'h1);
    step(1, acc);
    step(0, acc);
    check_val("timeout_sticky", 32'(terr), 32'h1);

    // Reset pulled while a write is in flight.
    set_pixel(0, 100, 200, 4, 5, 6);
    step(0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_write", 32'(wr), 32'h0);
    check_val("midrst_be", 32'(be), 32'h0);
    check_val("midrst_address", addr, 32'h0);
    check_val("midrst_busy", 32'(busy), 32'h0);
    for (int i = 0; i < N; i++) lv[i] = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Both lanes always valid, zero-wait acknowledge: strict alternation.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < N; i++) if (!lv[i]) set_pixel(i, $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom, $urandom, $urandom);
      step(0, acc);
      check_val("rr_sequence", 32'(acc), 32'(p % 2));
      step(1, acc);
    end
    for (int i = 0; i < N; i++) lv[i] = 0;
    step(0, acc);

    // Right edge: x = FB_WIDTH, y = 0.
    set_pixel(0, 800, 0, 1, 1, 1);
    step(0, acc);
    check_val("edge_accept", 32'(acc), 32'h0);
`ifdef FB_CLIP_EN
    check_val("edge_no_write", 32'(wr), 32'h0);
    check_val("edge_clip_count", 32'(clip_count), 32'h1);
    step(0, acc);
`else
    check_val("edge_address", addr, 32'h3200_0C80);
    step(1, acc);
`endif
    step(0, acc);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!lv[i] && $urandom_range(0, 1) == 0) new_pixel(i);
        else if (lv[i] && $urandom_range(0, 15) == 0) lv[i] = 0;
      end
      step($urandom_range(0, 2) == 0, acc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
